// File: rtl/mem_burst_ctrl.sv
// rtl/mem_burst_ctrl.sv - burst controller mastering memory1, one single-word access per beat
// Write beats pull from the s_* stream; read beats push to the m_* stream.
module mem_burst_ctrl #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_rd_wr_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [LEN_WIDTH-1:0]  cmd_len_i,
  input  logic                  s_valid_i,
  output logic                  s_ready_o,
  input  logic [WIDTH-1:0]      s_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [WIDTH-1:0]      m_data_o,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic                  mem_rd_wr_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0]      mem_wdata_o,
  input  logic [WIDTH-1:0]      mem_rdata_i,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [2:0] {
    IDLE, WR_FETCH, WR_REQ, RD_REQ, RD_CAP, RD_OUT, DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [LEN_WIDTH-1:0]  ONE_BEAT  = LEN_WIDTH'(1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] addr_next;

  // Explicit compare keeps the wrap correct for non-power-of-2 depths.
  assign addr_next = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_WIDTH'(1);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          addr_d = cmd_addr_i;
          cnt_d  = cmd_len_i;
          if (cmd_len_i == '0)   state_d = DONE;
          else if (cmd_rd_wr_i)  state_d = WR_FETCH;
          else                   state_d = RD_REQ;
        end
      end
      WR_FETCH: begin
        if (s_valid_i) begin
          wdata_d = s_data_i;
          state_d = WR_REQ;
        end
      end
      WR_REQ: begin
        if (mem_ready_i) begin
          addr_d  = addr_next;
          cnt_d   = cnt_q - ONE_BEAT;
          state_d = (cnt_q == ONE_BEAT) ? DONE : WR_FETCH;
        end
      end
      RD_REQ: begin
        if (mem_ready_i) state_d = RD_CAP;
      end
      RD_CAP: begin
        // memory1 presents read data the cycle after the request handshake.
        rdata_d = mem_rdata_i;
        state_d = RD_OUT;
      end
      RD_OUT: begin
        if (m_ready_i) begin
          addr_d  = addr_next;
          cnt_d   = cnt_q - ONE_BEAT;
          state_d = (cnt_q == ONE_BEAT) ? DONE : RD_REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign s_ready_o   = (state_q == WR_FETCH);
  assign m_valid_o   = (state_q == RD_OUT);
  assign mem_valid_o = (state_q == WR_REQ) || (state_q == RD_REQ);
  assign mem_rd_wr_o = (state_q == WR_REQ);
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign m_data_o    = rdata_q;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb/tb_mem_burst_ctrl.sv - scoreboard bench for mem_burst_ctrl with a behavioural memory1
module tb_mem_burst_ctrl;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int LW    = 5;

  logic             clk = 1'b0;
  logic             rst_i;
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic             cmd_rd_wr_i;
  logic [AW-1:0]    cmd_addr_i;
  logic [LW-1:0]    cmd_len_i;
  logic             s_valid_i;
  logic             s_ready_o;
  logic [WIDTH-1:0] s_data_i;
  logic             m_valid_o;
  logic             m_ready_i;
  logic [WIDTH-1:0] m_data_o;
  logic             mem_valid_o;
  logic             mem_ready_i;
  logic             mem_rd_wr_o;
  logic [AW-1:0]    mem_addr_o;
  logic [WIDTH-1:0] mem_wdata_o;
  logic [WIDTH-1:0] mem_rdata_i;
  logic             busy_o;
  logic             done_o;

  mem_burst_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_rd_wr_i(cmd_rd_wr_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_rd_wr_o(mem_rd_wr_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             rw;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } mem_exp_t;

  mem_exp_t         exp_mem_q[$];
  logic [WIDTH-1:0] exp_rd_q[$];
  logic [WIDTH-1:0] src_q[$];
  logic [WIDTH-1:0] ref_mem[DEPTH];
  logic [WIDTH-1:0] mem_model[DEPTH];
  mem_exp_t         mon_e;
  logic [WIDTH-1:0] mon_d;
  logic             s_hs;
  int               checks = 0;
  int               errors = 0;
  int               done_cnt = 0;
  int               m_hs_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural memory1: writes land at the handshake, read data follows one cycle later.
  always @(posedge clk) begin
    if (mem_valid_o && mem_ready_i) begin
      if (mem_rd_wr_o) mem_model[mem_addr_o] <= mem_wdata_o;
      else             mem_rdata_i <= mem_model[mem_addr_o];
    end
  end

  // Write-data source: presents the head of src_q, pops on handshake.
  initial begin
    s_valid_i = 1'b0;
    s_data_i  = '0;
    forever begin
      @(negedge clk);
      s_hs = s_valid_i && s_ready_o;
      @(posedge clk);
      #1;
      if (s_hs && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0) begin
        s_valid_i = 1'b1;
        s_data_i  = src_q[0];
      end else begin
        s_valid_i = 1'b0;
      end
    end
  end

  // Scoreboard monitor: handshakes sampled mid-cycle complete at the next rising edge.
  always @(negedge clk) begin
    if (mem_valid_o && mem_ready_i) begin
      if (exp_mem_q.size() == 0) check("mem_unexpected", 32'd1, 32'd0);
      else begin
        mon_e = exp_mem_q.pop_front();
        check("mem_rd_wr", mem_rd_wr_o, mon_e.rw);
        check("mem_addr", mem_addr_o, mon_e.addr);
        if (mon_e.rw) check("mem_wdata", mem_wdata_o, mon_e.data);
      end
    end
    if (m_valid_o && m_ready_i) begin
      m_hs_cnt++;
      if (exp_rd_q.size() == 0) check("m_unexpected", 32'd1, 32'd0);
      else begin
        mon_d = exp_rd_q.pop_front();
        check("m_data", m_data_o, mon_d);
      end
    end
    if (done_o) done_cnt++;
  end

  task automatic start_cmd(input logic wr, input logic [AW-1:0] addr, input logic [LW-1:0] len,
                           input logic [WIDTH-1:0] base);
    for (int i = 0; i < int'(len); i++) begin
      logic [AW-1:0] a;
      a = addr + AW'(i);
      if (wr) begin
        exp_mem_q.push_back('{1'b1, a, base + WIDTH'(i)});
        src_q.push_back(base + WIDTH'(i));
        ref_mem[a] = base + WIDTH'(i);
      end else begin
        exp_mem_q.push_back('{1'b0, a, '0});
        exp_rd_q.push_back(ref_mem[a]);
      end
    end
    cmd_valid_i = 1'b1;
    cmd_rd_wr_i = wr;
    cmd_addr_i  = addr;
    cmd_len_i   = len;
    check("cmd_ready_idle", cmd_ready_o, 1'b1);
    tick();
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cycles);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (!done_o && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, done_o, 1'b1);
    check({tag, "_cmd_ready_in_done"}, cmd_ready_o, 1'b0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done_o, 1'b0);
    check({tag, "_cmd_ready_after"}, cmd_ready_o, 1'b1);
    tick();
    check({tag, "_done_count"}, done_cnt, d0 + 1);
    check({tag, "_mem_q_empty"}, exp_mem_q.size(), 0);
    check({tag, "_rd_q_empty"}, exp_rd_q.size(), 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cmd_ready"}, cmd_ready_o, 1'b1);
    check({tag, "_s_ready"}, s_ready_o, 1'b0);
    check({tag, "_m_valid"}, m_valid_o, 1'b0);
    check({tag, "_mem_valid"}, mem_valid_o, 1'b0);
    check({tag, "_mem_rd_wr"}, mem_rd_wr_o, 1'b0);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_done"}, done_o, 1'b0);
    check({tag, "_mem_addr"}, mem_addr_o, 0);
    check({tag, "_mem_wdata"}, mem_wdata_o, 0);
    check({tag, "_m_data"}, m_data_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int d0;
    rst_i       = 1'b1;
    cmd_valid_i = 1'b0;
    cmd_rd_wr_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_len_i   = '0;
    m_ready_i   = 1'b1;
    mem_ready_i = 1'b1;
    repeat (3) tick();
    check_reset_vals("reset");
    rst_i = 1'b0;
    tick();

    // Full write then full read.
    start_cmd(1'b1, 4'd0, 5'd16, 8'h10);
    check("wr_latency_s_ready", s_ready_o, 1'b1);
    check("wr_busy", busy_o, 1'b1);
    wait_done("wr_full", 200);
    start_cmd(1'b0, 4'd0, 5'd16, 8'h00);
    check("rd_latency_mem_valid", mem_valid_o, 1'b1);
    check("rd_latency_dir", mem_rd_wr_o, 1'b0);
    wait_done("rd_full", 200);

    // Wrap-around: addresses 14, 15, 0, 1.
    start_cmd(1'b1, 4'd14, 5'd4, 8'h30);
    wait_done("wr_wrap", 100);
    start_cmd(1'b0, 4'd14, 5'd4, 8'h00);
    wait_done("rd_wrap", 100);

    // Memory backpressure during a write request.
    mem_ready_i = 1'b0;
    start_cmd(1'b1, 4'd5, 5'd2, 8'hA0);
    n = 0;
    while (!mem_valid_o && n < 20) begin tick(); n++; end
    check("wbp_mem_valid", mem_valid_o, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("wbp_hold_valid", mem_valid_o, 1'b1);
      check("wbp_hold_addr", mem_addr_o, 4'd5);
      check("wbp_hold_data", mem_wdata_o, 8'hA0);
    end
    mem_ready_i = 1'b1;
    wait_done("wr_bp", 100);

    // Read-stream backpressure: no new memory request while m_valid_o waits.
    m_ready_i = 1'b0;
    start_cmd(1'b0, 4'd5, 5'd2, 8'h00);
    n = 0;
    while (!m_valid_o && n < 20) begin tick(); n++; end
    check("rbp_m_valid", m_valid_o, 1'b1);
    check("rbp_m_data", m_data_o, 8'hA0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rbp_hold_valid", m_valid_o, 1'b1);
      check("rbp_hold_data", m_data_o, 8'hA0);
      check("rbp_no_mem_req", mem_valid_o, 1'b0);
    end
    m_ready_i = 1'b1;
    wait_done("rd_bp", 100);

    // Zero-length bursts in both directions.
    for (int w = 0; w < 2; w++) begin
      start_cmd(w[0], 4'd7, 5'd0, 8'h00);
      check("len0_done", done_o, 1'b1);
      check("len0_mem_valid", mem_valid_o, 1'b0);
      check("len0_s_ready", s_ready_o, 1'b0);
      check("len0_m_valid", m_valid_o, 1'b0);
      check("len0_cmd_ready_n1", cmd_ready_o, 1'b0);
      tick();
      check("len0_cmd_ready_n2", cmd_ready_o, 1'b1);
      check("len0_done_pulse", done_o, 1'b0);
    end

    // Reset during beat 5 of a 16-beat read.
    start_cmd(1'b0, 4'd0, 5'd16, 8'h00);
    base = m_hs_cnt;
    n = 0;
    while (m_hs_cnt < base + 4 && n < 100) begin tick(); n++; end
    check("rst_mid_reached_beat5", m_hs_cnt, base + 4);
    d0 = done_cnt;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_reset_vals("rst_mid");
    exp_mem_q.delete();
    exp_rd_q.delete();
    src_q.delete();
    repeat (3) tick();
    check("rst_mid_no_done", done_cnt, d0);
    start_cmd(1'b1, 4'd3, 5'd2, 8'h55);
    wait_done("post_rst_wr", 100);
    start_cmd(1'b0, 4'd3, 5'd2, 8'h00);
    wait_done("post_rst_rd", 100);

    repeat (5) tick();
    check("final_mem_q_empty", exp_mem_q.size(), 0);
    check("final_src_q_empty", src_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_burst_ctrl.md
# mem_burst_ctrl

Burst access controller that sits directly upstream of `memory1` and is its only master. It accepts one burst command (direction, start address, length), then issues one single-word `memory1` access per beat over the valid/ready port. Write data is pulled from an input stream; read data is pushed to an output stream. Each stream has its own valid/ready handshake.

## Interface
- `WIDTH`, 8, data word width; matches `memory1`.
- `DEPTH`, 16, number of memory words; matches `memory1`.
- `ADDR_WIDTH`, `$clog2(DEPTH)`, address width.
- `LEN_WIDTH`, `ADDR_WIDTH+1`, burst length width; legal lengths are 0..DEPTH.

Ports:
- `clk_i`  in  1  single clock; all logic is on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `cmd_valid_i`  in  1  burst command valid.
- `cmd_ready_o`  out  1  controller idle; command accepted when both are high at a rising edge.
- `cmd_rd_wr_i`  in  1  1 = write burst, 0 = read burst (same encoding as `memory1`).
- `cmd_addr_i`  in  ADDR_WIDTH  start address.
- `cmd_len_i`  in  LEN_WIDTH  number of beats.
- `s_valid_i`  in  1  write-data stream valid.
- `s_ready_o`  out  1  write-data stream ready.
- `s_data_i`  in  WIDTH  write data.
- `m_valid_o`  out  1  read-data stream valid.
- `m_ready_i`  in  1  read-data stream ready.
- `m_data_o`  out  WIDTH  read data.
- `mem_valid_o`  out  1  memory request valid.
- `mem_ready_i`  in  1  memory ready.
- `mem_rd_wr_o`  out  1  memory direction.
- `mem_addr_o`  out  ADDR_WIDTH  memory address.
- `mem_wdata_o`  out  WIDTH  memory write data.
- `mem_rdata_i`  in  WIDTH  memory read data.
- `busy_o`  out  1  high whenever state is not IDLE.
- `done_o`  out  1  one-cycle pulse when a burst completes.

## Operation
- States: IDLE, WR_FETCH, WR_REQ, RD_REQ, RD_CAP, RD_OUT, DONE.
- **IDLE**
  - `cmd_ready_o`=1.
  - On accept, latch direction, address and length into working registers.
  - len=0 goes to DONE.
  - Write goes to WR_FETCH; read goes to RD_REQ.
- **WR_FETCH**
  - `s_ready_o`=1.
  - On `s_valid_i`, register `s_data_i` and go to WR_REQ.
- **WR_REQ**
  - `mem_valid_o`=1, `mem_rd_wr_o`=1, with current address and registered data.
  - On `mem_ready_i`: address advances, remaining count decrements.
  - If the remaining count becomes 0, go to DONE; otherwise go to WR_FETCH.
- **RD_REQ**
  - `mem_valid_o`=1, `mem_rd_wr_o`=0.
  - On `mem_ready_i`, go to RD_CAP.
- **RD_CAP**
  - Register `mem_rdata_i` into the `m_data_o` register.
  - `memory1` read data is valid the cycle after the request handshake.
  - Go to RD_OUT.
- **RD_OUT**
  - `m_valid_o`=1.
  - On `m_ready_i`: address advances, count decrements.
  - Go to DONE if the count becomes 0; otherwise go to RD_REQ.
- **DONE**
  - `done_o`=1 for exactly one cycle, then go to IDLE.
- Address arithmetic:
  - Next address is addr+1, wrapping to 0 after DEPTH-1.
  - For non-power-of-2 DEPTH, the wrap is an explicit compare.
- Handshake rules:
  - `mem_valid_o` and `m_valid_o`, once asserted, stay high with stable payload until their handshake completes; never withdrawn.
  - At most one memory request is outstanding.
  - Commands are not accepted while busy; `cmd_*` inputs are ignored outside IDLE.
  - `s_ready_o` is high only in WR_FETCH; `s_valid_i` is ignored in all other states.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from any `*_ready_i` or `*_valid_i` to any output.
- Reset values:
  - State IDLE.
  - `cmd_ready_o`=1 (decoded from IDLE).
  - `s_ready_o`=0, `m_valid_o`=0, `mem_valid_o`=0, `mem_rd_wr_o`=0, `busy_o`=0, `done_o`=0.
  - `mem_addr_o`=0, `mem_wdata_o`=0, `m_data_o`=0.
- Reset mid-burst:
  - Burst is abandoned at the reset edge; no `done_o`.
  - All outputs take their reset values in the following cycle.
- Latency, with the command accepted at edge N:
  - Read: `mem_valid_o` is high in cycle N+1.
  - Write: `s_ready_o` is high in cycle N+1.
  - len=0: `done_o` is high in cycle N+1 and `cmd_ready_o` is high in cycle N+2.
- Per-beat minimum with no stalls:
  - Write: 2 cycles (WR_FETCH, WR_REQ).
  - Read: 3 cycles (RD_REQ, RD_CAP, RD_OUT).
- `done_o` is asserted in the cycle after the final beat's handshake.
- `cmd_ready_o` is high in the cycle after that, so the next command can be accepted no earlier than 2 cycles after the last beat.

## Test plan
- **Full write burst:** write, addr 0, len 16, stream 0x10..0x1F -> 16 mem writes at addresses 0..15 with data 0x10..0x1F in order; exactly one `done_o`.
- **Full read burst:** read, addr 0, len 16 after the write above -> `m_data_o` sequence 0x10..0x1F; one `mem_valid_o` handshake per beat; `done_o` once.
- **Wrap-around:** write, addr 14, len 4 -> `mem_addr_o` sequence 14, 15, 0, 1.
- **Backpressure:**
  - `m_ready_i` held low 3 cycles in RD_OUT -> `m_valid_o` stays high, `m_data_o` stable, no new memory request.
  - `mem_ready_i` low 2 cycles in WR_REQ -> address and data stable.
- **Zero length:** len=0 -> no memory or stream activity; `done_o` in cycle N+1.
- **Reset mid-burst:** `rst_i` pulse during beat 5 of a 16-beat read -> the next cycle shows all reset values and no `done_o`; a new command is accepted afterwards and completes normally.
